key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event_pkg.sv | 22 ++
 rtl/key_fsm.sv | 125 ++++++++++++
 rtl/key_event.sv | 61 ++++++
 tb/tb_key_event.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event push-button block: per-key FSM
// state encoding, default timing parameters and a counter-width helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } key_state_t;

  localparam int DEF_SAMPLE_DIV = 500000;
  localparam int DEF_STABLE_CNT = 2;
  localparam int DEF_LONG_CNT   = 100;
  localparam int DEF_REPEAT_CNT = 20;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// One push-button channel: 2-flop synchronizer, tick-based debounce and
// the IDLE/HELD/LONG press classifier with registered one-clk event pulses.
// Auto-repeat while in LONG exists only when KEY_EVENT_REPEAT_EN is defined;
// otherwise LONG is a terminal holding state and o_repeat is tied low.
module key_fsm
  import key_event_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
  output logic o_level,
  output logic o_press,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_release
);

  localparam int STABLE_W = cnt_width(STABLE_CNT);
  localparam int HOLD_W   = cnt_width((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT);

  logic                sync1;
  logic                sync2;
  logic                sample;
  logic                accept;
  logic [STABLE_W-1:0] stable_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  key_state_t          state;

  // Bring the raw active-low button into the clk domain; resets to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Active-high view of the button, and the tick on which a new level is accepted.
  assign sample = ~sync2;
  assign accept = tick && (sample != o_level) &&
                  (stable_cnt == STABLE_W'(STABLE_CNT - 1));

  // Debounce plus press classification; a level change takes priority over
  // the hold-time thresholds, so a release on the long tick reads as short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      hold_cnt   <= '0;
      state      <= ST_IDLE;
      o_level    <= 1'b0;
      o_press    <= 1'b0;
      o_short    <= 1'b0;
      o_long     <= 1'b0;
      o_release  <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      o_repeat   <= 1'b0;
`endif
    end else begin
      o_press   <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_release <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      o_repeat  <= 1'b0;
`endif
      if (tick) begin
        if (sample == o_level || accept) begin
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end

        if (accept) begin
          o_level  <= sample;
          hold_cnt <= '0;
          if (sample) begin
            state   <= ST_HELD;
            o_press <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            o_release <= 1'b1;
            o_short   <= (state == ST_HELD);
          end
        end else begin
          case (state)
            ST_HELD: begin
              if (hold_cnt == HOLD_W'(LONG_CNT - 1)) begin
                state    <= ST_LONG;
                o_long   <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            ST_LONG: begin
`ifdef KEY_EVENT_REPEAT_EN
              if (hold_cnt == HOLD_W'(REPEAT_CNT - 1)) begin
                o_repeat <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
`endif
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

`ifndef KEY_EVENT_REPEAT_EN
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_event.sv
// Multi-key push-button event detector. A shared sample tick drives
// NUM_KEYS independent key_fsm channels. Define KEY_EVENT_REPEAT_EN to
// enable auto-repeat pulses while a key is held past the long-press point.
module key_event
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] i_sw,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_short,
  output logic [NUM_KEYS-1:0] o_long,
  output logic [NUM_KEYS-1:0] o_repeat,
  output logic [NUM_KEYS-1:0] o_release
);

  localparam int TICK_W = cnt_width(SAMPLE_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // Free-running divider; tick is high for one clk every SAMPLE_DIV clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_fsm #(
      .STABLE_CNT(STABLE_CNT),
      .LONG_CNT  (LONG_CNT),
      .REPEAT_CNT(REPEAT_CNT)
    ) u_key (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .sw       (i_sw[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_short  (o_short[g]),
      .o_long   (o_long[g]),
      .o_repeat (o_repeat[g]),
      .o_release(o_release[g])
    );
  end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event with small timing parameters.
// Honours KEY_EVENT_REPEAT_EN in its reference model and expectations.
module tb_key_event;

  localparam int NK = 4;
  localparam int SD = 4;
  localparam int STABLE_CNT = 2;
  localparam int LONG_CNT = 5;
  localparam int REPEAT_CNT = 2;
`ifdef KEY_EVENT_REPEAT_EN
  localparam int EXP_REPEATS = 3;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] i_sw = '1;
  logic [NK-1:0] o_level, o_press, o_short, o_long, o_repeat, o_release;

  int total = 0;
  int bad = 0;

  key_event #(
    .NUM_KEYS(NK), .SAMPLE_DIV(SD), .STABLE_CNT(STABLE_CNT),
    .LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
    .o_level(o_level), .o_press(o_press), .o_short(o_short),
    .o_long(o_long), .o_repeat(o_repeat), .o_release(o_release)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] sw, input int cycles);
    i_sw = sw;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: ticks land on every SD-th clk edge after reset release;
  // each tick sees the button as it was two edges earlier. A level is
  // accepted after STABLE_CNT consecutive differing samples. Events are
  // derived from the number of ticks elapsed since the accepted press.
  logic [NK-1:0] exp_level = '0, exp_press = '0, exp_short = '0;
  logic [NK-1:0] exp_long = '0, exp_repeat = '0, exp_release = '0;
  logic [NK-1:0] sw_hist[$];
  int edge_n = 0;
  int diff_run[NK] = '{default: 0};
  int held_ticks[NK] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0;
      sw_hist.delete();
      exp_level = '0; exp_press = '0; exp_short = '0;
      exp_long = '0; exp_repeat = '0; exp_release = '0;
      for (int k = 0; k < NK; k++) begin
        diff_run[k] = 0;
        held_ticks[k] = 0;
      end
    end else begin
      edge_n++;
      exp_press = '0; exp_short = '0; exp_long = '0;
      exp_repeat = '0; exp_release = '0;
      if (edge_n % SD == 0) begin
        for (int k = 0; k < NK; k++) begin
          logic down;
          down = (sw_hist.size() >= 2) ? ~sw_hist[sw_hist.size() - 2][k] : 1'b0;
          if (down != exp_level[k]) diff_run[k]++;
          else diff_run[k] = 0;
          if (diff_run[k] == STABLE_CNT) begin
            diff_run[k] = 0;
            exp_level[k] = down;
            if (down) begin
              exp_press[k] = 1'b1;
              held_ticks[k] = 0;
            end else begin
              exp_release[k] = 1'b1;
              exp_short[k] = (held_ticks[k] < LONG_CNT);
            end
          end else if (exp_level[k]) begin
            held_ticks[k]++;
            if (held_ticks[k] == LONG_CNT) exp_long[k] = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
            else if (held_ticks[k] > LONG_CNT &&
                     (held_ticks[k] - LONG_CNT) % REPEAT_CNT == 0) exp_repeat[k] = 1'b1;
`endif
          end
        end
      end
      sw_hist.push_back(i_sw);
      if (sw_hist.size() > 4) void'(sw_hist.pop_front());
    end
  end

  // Pulse tallies used by the directed scenario checks.
  int cnt_press[NK], cnt_short[NK], cnt_long[NK], cnt_repeat[NK], cnt_release[NK];

  task automatic clearCounts();
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] = 0; cnt_short[k] = 0; cnt_long[k] = 0;
      cnt_repeat[k] = 0; cnt_release[k] = 0;
    end
  endtask

  function automatic int allPulses();
    int s;
    s = 0;
    for (int k = 0; k < NK; k++)
      s += cnt_press[k] + cnt_short[k] + cnt_long[k] + cnt_repeat[k] + cnt_release[k];
    return s;
  endfunction

  // Every cycle: compare all outputs with the model and tally pulses.
  always @(negedge clk) begin
    checkOutput("level", int'(o_level), int'(exp_level));
    checkOutput("press", int'(o_press), int'(exp_press));
    checkOutput("short", int'(o_short), int'(exp_short));
    checkOutput("long", int'(o_long), int'(exp_long));
    checkOutput("repeat", int'(o_repeat), int'(exp_repeat));
    checkOutput("release", int'(o_release), int'(exp_release));
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] += int'(o_press[k]);
      cnt_short[k] += int'(o_short[k]);
      cnt_long[k] += int'(o_long[k]);
      cnt_repeat[k] += int'(o_repeat[k]);
      cnt_release[k] += int'(o_release[k]);
    end
  end

  initial begin
    int e;
    logic [NK-1:0] cur;
    clearCounts();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                int'({o_level, o_press, o_short, o_long, o_repeat, o_release}), 0);
    rst_n = 1'b1;
    applyStimulus('1, 8 * SD);

    $display("[TB] glitch shorter than debounce");
    clearCounts();
    applyStimulus(4'b1110, SD);
    applyStimulus(4'b1111, 10 * SD);
    checkOutput("glitch_pulses", allPulses(), 0);
    checkOutput("glitch_level", int'(o_level), 0);

    $display("[TB] short press");
    clearCounts();
    applyStimulus(4'b1110, 4 * SD);
    applyStimulus(4'b1111, 12 * SD);
    checkOutput("short_press_cnt", cnt_press[0], 1);
    checkOutput("short_short_cnt", cnt_short[0], 1);
    checkOutput("short_release_cnt", cnt_release[0], 1);
    checkOutput("short_long_cnt", cnt_long[0], 0);

    $display("[TB] long press with repeat");
    clearCounts();
    applyStimulus(4'b1101, 12 * SD);
    applyStimulus(4'b1111, 12 * SD);
    checkOutput("long_press_cnt", cnt_press[1], 1);
    checkOutput("long_long_cnt", cnt_long[1], 1);
    checkOutput("long_repeat_cnt", cnt_repeat[1], EXP_REPEATS);
    checkOutput("long_short_cnt", cnt_short[1], 0);
    checkOutput("long_release_cnt", cnt_release[1], 1);

    $display("[TB] release on the long threshold tick");
    clearCounts();
    applyStimulus(4'b1110, LONG_CNT * SD);
    applyStimulus(4'b1111, 12 * SD);
    checkOutput("edge_short_cnt", cnt_short[0], 1);
    checkOutput("edge_release_cnt", cnt_release[0], 1);
    checkOutput("edge_long_cnt", cnt_long[0], 0);

    $display("[TB] all keys at once");
    i_sw = 4'b0000;
    e = 0;
    while (o_press == '0 && e < 20 * SD) begin
      @(negedge clk);
      e++;
    end
    checkOutput("all_press", int'(o_press), 15);
    applyStimulus(4'b0000, 3 * SD);
    applyStimulus(4'b1111, 12 * SD);

    $display("[TB] random stimulus");
    cur = '1;
    repeat (200) begin
      cur = cur ^ (4'($urandom) & 4'($urandom));
      applyStimulus(cur, int'($urandom_range(1, 8 * SD)));
    end
    applyStimulus('1, 15 * SD);

    $display("[TB] reset while held in long");
    clearCounts();
    applyStimulus(4'b1011, 12 * SD);
    checkOutput("held_level", int'(o_level[2]), 1);
    checkOutput("held_long_cnt", cnt_long[2], 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_immediate",
                   int'({o_level, o_press, o_short, o_long, o_repeat, o_release}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    while (e < 10 * SD) begin
      @(posedge clk);
      e++;
      #1;
      if (o_press[2]) break;
    end
    checkOutput("repress_edge", e, 2 * SD);
    applyStimulus(4'b1011, 2 * SD);
    applyStimulus('1, 12 * SD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
